multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle combinational control decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives datapath controls per state.
- Combines opcode decode and funct-to-ALU-control decode behind a registered instruction latch.
- Sits between instruction-memory handshake, ALU (zero flag) and data-memory handshake.

Parameters:
- OPCODE_W, 6, opcode field width.
- FUNCT_W, 6, funct field width.
- ALU_CTRL_W, 3, ALU control width; must be >= 3, bits above [2:0] driven 0.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  instruction memory presents opcode/fn_code
- instr_ready  out  1  unit accepts an instruction
- opcode  in  OPCODE_W  instruction opcode
- fn_code  in  FUNCT_W  R-type funct field
- zero  in  1  ALU zero flag, sampled in EXECUTE
- mem_ready  in  1  data memory completes access
- RegWrite  out  1  register-file write strobe
- ALUtoReg  out  1  1 = ALU result to register file, 0 = memory data
- ALUSrc  out  1  1 = immediate operand
- MemRead  out  1  data read request
- MemWrite  out  1  data write request
- Branch_taken  out  1  PC loads branch target
- PCWrite  out  1  PC update strobe
- ALU_cntrl  out  ALU_CTRL_W  ALU operation
- illegal  out  1  unsupported opcode/funct pulse
- busy  out  1  high in every state except FETCH

Behaviour:
- State register: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4. Reset -> FETCH. Out-of-range encodings -> FETCH.
- Outputs: Moore-style, decoded from the state register and the latched IR (opc_q, fn_q). No combinational path from opcode/fn_code to outputs.
- Reset: all outputs 0 while reset is high, including instr_ready. IR is cleared to 0. From the first cycle after reset, instr_ready=1.
- FETCH:
  - instr_ready=1.
  - On instr_valid & instr_ready: latch opcode/fn_code, go to DECODE.
  - Otherwise hold.
- DECODE (1 cycle):
  - Classify the instruction.
  - Supported: R-type (opc 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; addi 0x08; lw 0x23; sw 0x2B; beq 0x04.
  - Unsupported: illegal=1 and PCWrite=1 for this cycle, go to FETCH.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - ALU_cntrl mapping: add/addi/lw/sw = 010, sub/beq = 110, and = 000, or = 001, slt = 111.
  - ALUSrc=1 for addi/lw/sw.
  - beq: Branch_taken=zero, PCWrite=1, go to FETCH.
  - lw/sw: go to MEM.
  - R-type/addi: go to WB.
- MEM:
  - lw: MemRead=1 held; sw: MemWrite=1 held; ALU_cntrl=010 and ALUSrc=1 held until mem_ready.
  - On mem_ready, sw: PCWrite=1, go to FETCH.
  - On mem_ready, lw: go to WB.
  - mem_ready high on the first MEM cycle completes in 1 cycle.
- WB (1 cycle):
  - RegWrite=1, PCWrite=1, go to FETCH.
  - ALUtoReg=1 for R-type/addi, 0 for lw.
- Latency (accept edge to return to FETCH):
  - beq: 3 cycles
  - R-type/addi: 4 cycles
  - sw: 3 cycles + MEM wait cycles
  - lw: 4 cycles + MEM wait cycles
  - illegal: 2 cycles
- Outside the states listed above, all strobes are 0 and ALU_cntrl=0.
- Inputs outside their sampling state are ignored:
  - opcode/fn_code changing after acceptance have no effect.
  - mem_ready outside MEM is ignored.
  - instr_valid outside FETCH is ignored; instr_ready=0 there.
- Reset mid-instruction: next cycle is FETCH, all strobes 0, no partial RegWrite/MemWrite issued.

Optional Feature:
- Macro: MCU_PERF_CNT_EN.
- Defined:
  - Adds outputs instret_cnt[31:0] and cycle_cnt[31:0].
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on each PCWrite of a legal instruction.
  - Both counters clear on reset and wrap 0xFFFFFFFF -> 0.
- Undefined: the ports and counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset held 3 cycles with instr_valid=1 -> all outputs 0, instr_ready=0. Release reset -> instr_ready=1 next cycle.
- R-type add (opc 0x00, fn 0x20) -> DECODE, then EXECUTE with ALU_cntrl=010, ALUSrc=0, then WB with RegWrite=1, ALUtoReg=1, PCWrite=1; back to FETCH 4 cycles after accept.
- lw (0x23), mem_ready low 2 cycles then high -> MemRead=1 for 3 cycles, then WB with RegWrite=1, ALUtoReg=0.
- sw (0x2B) with mem_ready=1 immediately -> MemWrite=1 for 1 cycle, PCWrite=1 that cycle, RegWrite never asserted.
- beq (0x04) with zero=1 -> EXECUTE: ALU_cntrl=110, Branch_taken=1, PCWrite=1. Repeat with zero=0 -> Branch_taken=0, PCWrite=1.
- Illegal opc 0x3F, then R-type fn 0x00 -> illegal=1 for exactly one cycle in DECODE each time, no RegWrite. Separately, reset asserted in MEM of an sw -> MemWrite=0 next cycle, state FETCH.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencer driving
// datapath strobes from the state register and a latched instruction register.
//
// Ports:
//   clk, reset (sync, active-high)
//   instr_valid/instr_ready : instruction-memory handshake, opcode/fn_code
//   zero                    : ALU zero flag (used in EXECUTE for beq)
//   mem_ready               : data-memory completion (used in MEM)
//   RegWrite, ALUtoReg, ALUSrc, MemRead, MemWrite, Branch_taken, PCWrite,
//   ALU_cntrl, illegal, busy : datapath controls / status
// Optional: define MCU_PERF_CNT_EN to add instret_cnt/cycle_cnt counters.

module multicycle_control_unit #(
  parameter int OPCODE_W   = 6,
  parameter int FUNCT_W    = 6,
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0]    fn_code,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  RegWrite,
  output logic                  ALUtoReg,
  output logic                  ALUSrc,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  Branch_taken,
  output logic                  PCWrite,
  output logic [ALU_CTRL_W-1:0] ALU_cntrl,
  output logic                  illegal,
  output logic                  busy
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [31:0]           instret_cnt,
  output logic [31:0]           cycle_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'('h00);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'('h08);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'('h23);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'('h2B);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'('h04);

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'('h20);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'('h22);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'('h24);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'('h25);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'('h2A);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opc_q, opc_d;
  logic [FUNCT_W-1:0]  fn_q, fn_d;

  logic       is_r, is_addi, is_lw, is_sw, is_beq;
  logic       r_ok, legal, is_imm;
  logic [2:0] r_alu, alu_ex, alu3;

  // Instruction classification, purely from the latched IR
  always_comb begin
    is_r    = (opc_q == OP_R);
    is_addi = (opc_q == OP_ADDI);
    is_lw   = (opc_q == OP_LW);
    is_sw   = (opc_q == OP_SW);
    is_beq  = (opc_q == OP_BEQ);
    r_ok    = 1'b1;
    r_alu   = ALU_ADD;
    case (fn_q)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      default: r_ok  = 1'b0;
    endcase
    legal  = (is_r && r_ok) || is_addi || is_lw
             || is_sw || is_beq;
    is_imm = is_addi || is_lw || is_sw;
    unique case (1'b1)
      is_beq:  alu_ex = ALU_SUB;
      is_r:    alu_ex = r_alu;
      default: alu_ex = ALU_ADD;
    endcase
  end

  // Next state and IR load
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    fn_d    = fn_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          opc_d   = opcode;
          fn_d    = fn_code;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = legal ? S_EXECUTE : S_FETCH;
      end
      S_EXECUTE: begin
        if (is_beq) begin
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      fn_q    <= fn_d;
    end
  end

  // Moore decode; reset forces everything low in the same cycle
  always_comb begin
    instr_ready  = 1'b0;
    RegWrite     = 1'b0;
    ALUtoReg     = 1'b0;
    ALUSrc       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Branch_taken = 1'b0;
    PCWrite      = 1'b0;
    illegal      = 1'b0;
    busy         = 1'b0;
    alu3         = 3'b000;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          instr_ready = 1'b1;
        end
        S_DECODE: begin
          busy = 1'b1;
          if (!legal) begin
            illegal = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_EXECUTE: begin
          busy   = 1'b1;
          alu3   = alu_ex;
          ALUSrc = is_imm;
          if (is_beq) begin
            Branch_taken = zero;
            PCWrite      = 1'b1;
          end
        end
        S_MEM: begin
          busy     = 1'b1;
          alu3     = ALU_ADD;
          ALUSrc   = 1'b1;
          MemRead  = is_lw;
          MemWrite = is_sw;
          PCWrite  = is_sw && mem_ready;
        end
        S_WB: begin
          busy     = 1'b1;
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          ALUtoReg = !is_lw;
        end
        default: begin
          busy = 1'b1;
        end
      endcase
    end
    ALU_cntrl      = '0;
    ALU_cntrl[2:0] = alu3;
  end

`ifdef MCU_PERF_CNT_EN
  logic [31:0] instret_q, instret_d;
  logic [31:0] cycle_q, cycle_d;

  // Illegal instructions only raise PCWrite in DECODE
  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    instret_d = instret_q;
    if (PCWrite && (state_q != S_DECODE)) begin
      instret_d = instret_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
      cycle_q   <= '0;
    end else begin
      instret_q <= instret_d;
      cycle_q   <= cycle_d;
    end
  end

  assign instret_cnt = instret_q;
  assign cycle_cnt   = cycle_q;
`endif

endmodule
